apb_req_master: RTL

APB4 initiator that turns a simple valid/ready request/response stream into APB transfers on the master side of the APB bus. It is the requester counterpart of the bus slaves in the APB-to-MIG bridge path. It is used by the verification harness and by on-chip control logic (calibration and config sequencers) to read and write the bridge's APB register/memory window. It issues one transfer at a time through an IDLE/SETUP/ACCESS/RESP state machine.

---
 rtl/apb_req_master.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/apb_req_master.sv
// APB4 initiator: converts a valid/ready request/response stream into single APB transfers.
// Optional ACCESS-phase timeout is enabled by defining APB_REQ_MASTER_TIMEOUT_EN.
module apb_req_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  pclk_i,
  input  logic                  preset_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [DATA_W-1:0]     req_wdata_i,
  input  logic [DATA_W/8-1:0]   req_strb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_W-1:0]     rsp_rdata_o,
  output logic                  rsp_slverr_o,
  output logic                  rsp_timeout_o,
  output logic [ADDR_W-1:0]     paddr_o,
  output logic [DATA_W-1:0]     pwdata_o,
  output logic                  pwrite_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic [DATA_W/8-1:0]   pstrb_o,
  input  logic [DATA_W-1:0]     prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic                timeout_hit_s;
  logic [ADDR_W-1:0]   paddr_r;
  logic [DATA_W-1:0]   pwdata_r;
  logic [STRB_W-1:0]   pstrb_r;
  logic                pwrite_r;
  logic                psel_r;
  logic                penable_r;
  logic                rsp_valid_r;
  logic [DATA_W-1:0]   rsp_rdata_r;
  logic                rsp_slverr_r;

  // Reject parameter sets that cannot form whole byte lanes or a usable timeout.
  if (((DATA_W % 8) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("apb_req_master: DATA_W must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
  end

`ifdef APB_REQ_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] wait_cnt_r;
  logic             rsp_timeout_r;

  // Limit reached on the last tolerated idle ACCESS cycle; pready in that cycle wins.
  assign timeout_hit_s = (state_r == ST_ACCESS) && !pready_i &&
                         (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count consecutive ACCESS cycles without pready, cleared while in SETUP.
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      wait_cnt_r <= '0;
    end else if (state_r == ST_SETUP) begin
      wait_cnt_r <= '0;
    end else if ((state_r == ST_ACCESS) && !pready_i) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end
  end

  // Timeout flag of the response, set only when the counter ends the transfer.
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      rsp_timeout_r <= 1'b0;
    end else if ((state_r == ST_ACCESS) && pready_i) begin
      rsp_timeout_r <= 1'b0;
    end else if (timeout_hit_s) begin
      rsp_timeout_r <= 1'b1;
    end
  end

  assign rsp_timeout_o = rsp_timeout_r;
`else
  assign timeout_hit_s = 1'b0;
  assign rsp_timeout_o = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid_i) begin
          state_nxt_s = ST_SETUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_nxt_s = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready_i || timeout_hit_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Latch the request on handshake; reads drive zero data and strobes.
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      paddr_r  <= '0;
      pwdata_r <= '0;
      pstrb_r  <= '0;
      pwrite_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && req_valid_i) begin
      paddr_r  <= req_addr_i;
      pwrite_r <= req_write_i;
      pwdata_r <= req_write_i ? req_wdata_i : '0;
      pstrb_r  <= req_write_i ? req_strb_i : '0;
    end
  end

  // Phase strobes registered from the next state so they align with SETUP/ACCESS/RESP.
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      psel_r      <= (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_ACCESS);
      penable_r   <= (state_nxt_s == ST_ACCESS);
      rsp_valid_r <= (state_nxt_s == ST_RESP);
    end
  end

  // Capture the completer response, or synthesize an error response on timeout.
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      rsp_rdata_r  <= '0;
      rsp_slverr_r <= 1'b0;
    end else if ((state_r == ST_ACCESS) && pready_i) begin
      rsp_rdata_r  <= pwrite_r ? '0 : prdata_i;
      rsp_slverr_r <= pslverr_i;
    end else if (timeout_hit_s) begin
      rsp_rdata_r  <= '0;
      rsp_slverr_r <= 1'b1;
    end
  end

  assign req_ready_o  = (state_r == ST_IDLE);
  assign paddr_o      = paddr_r;
  assign pwdata_o     = pwdata_r;
  assign pstrb_o      = pstrb_r;
  assign pwrite_o     = pwrite_r;
  assign psel_o       = psel_r;
  assign penable_o    = penable_r;
  assign rsp_valid_o  = rsp_valid_r;
  assign rsp_rdata_o  = rsp_rdata_r;
  assign rsp_slverr_o = rsp_slverr_r;

endmodule
